// File: rtl/matrix_alu_if.sv
// Operand/result bus of the 4x4 matrix unit.
// master: control engine side, slave: matrix_alu side.
interface matrix_alu_if #(
  parameter int ELEM_W = 16,
  parameter int N      = 4
);
  localparam int MW = N * N * ELEM_W;

  logic              start;
  logic [2:0]        opcode;
  logic [MW-1:0]     operand_a;
  logic [MW-1:0]     operand_b;
  logic [ELEM_W-1:0] scalar;
  logic              busy;
  logic              done;
  logic              error;
  logic [MW-1:0]     result;

  modport master (
    output start, opcode, operand_a, operand_b, scalar,
    input  busy, done, error, result
  );

  modport slave (
    input  start, opcode, operand_a, operand_b, scalar,
    output busy, done, error, result
  );
endinterface

// File: rtl/matrix_alu.sv
// Sequential 4x4 matrix unit: add/sub/mul/transpose/scalar.
// Ports: clk, reset (sync, high), bus (matrix_alu_if.slave).
module matrix_alu #(
  parameter int ELEM_W = 16,
  parameter int N      = 4
) (
  input  logic         clk,
  input  logic         reset,
  matrix_alu_if.slave  bus
);
  localparam int NE = N * N;
  localparam int MW = NE * ELEM_W;
  localparam int IW = $clog2(NE);
  localparam int PW = 2 * ELEM_W;
  localparam int AW = PW + $clog2(N);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_TR  = 3'd3;
  localparam logic [2:0] OP_SC  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW:0]       cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [MW-1:0]     a_q, a_d;
  logic [MW-1:0]     b_q, b_d;
  logic [ELEM_W-1:0] s_q, s_d;
  logic [MW-1:0]     res_q, res_d;
  logic              err_q, err_d;

  logic              is_add, is_sub, is_mul;
  logic              is_tr, is_sc;
  logic              last;
  logic [IW-1:0]     idx;
  logic [MW-1:0]     add_v, sub_v, tr_v, sc_v;
  logic [PW-1:0]     sc_p;
  logic [PW-1:0]     prod [N];
  logic [AW-1:0]     acc;
  logic [ELEM_W-1:0] mac;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign is_add = (op_q == OP_ADD);
  assign is_sub = (op_q == OP_SUB);
  assign is_mul = (op_q == OP_MUL);
  assign is_tr  = (op_q == OP_TR);
  assign is_sc  = (op_q == OP_SC);

  // Step 0 of EXEC only settles the latched operands; work
  // starts at step 1. Mul writes element cnt-1 at steps 1..NE.
  assign last = is_mul ? (cnt_q == (IW+1)'(NE))
                       : (cnt_q == (IW+1)'(1));
  assign idx  = IW'(cnt_q - 1'b1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = EXEC;
      EXEC: if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Whole-matrix element-wise results.
  always_comb begin
    add_v = '0;
    sub_v = '0;
    tr_v  = '0;
    sc_v  = '0;
    sc_p  = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        add_v[(r*N+c)*ELEM_W +: ELEM_W] =
          a_q[(r*N+c)*ELEM_W +: ELEM_W] +
          b_q[(r*N+c)*ELEM_W +: ELEM_W];
        sub_v[(r*N+c)*ELEM_W +: ELEM_W] =
          a_q[(r*N+c)*ELEM_W +: ELEM_W] -
          b_q[(r*N+c)*ELEM_W +: ELEM_W];
        tr_v[(r*N+c)*ELEM_W +: ELEM_W] =
          a_q[(c*N+r)*ELEM_W +: ELEM_W];
        sc_p = PW'(a_q[(r*N+c)*ELEM_W +: ELEM_W]) * PW'(s_q);
        sc_v[(r*N+c)*ELEM_W +: ELEM_W] = sc_p[ELEM_W-1:0];
      end
    end
  end

  // One mul element: N parallel products, full-width sum,
  // truncated only at the end.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      prod[k] =
        PW'(a_q[((int'(idx)/N)*N+k)*ELEM_W +: ELEM_W]) *
        PW'(b_q[(k*N+(int'(idx)%N))*ELEM_W +: ELEM_W]);
      acc = acc + AW'(prod[k]);
    end
    mac = acc[ELEM_W-1:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    res_d = res_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          op_d  = bus.opcode;
          a_d   = bus.operand_a;
          b_d   = bus.operand_b;
          s_d   = bus.scalar;
          err_d = 1'b0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          unique case (1'b1)
            is_add: res_d = add_v;
            is_sub: res_d = sub_v;
            is_tr:  res_d = tr_v;
            is_sc:  res_d = sc_v;
            is_mul: res_d[int'(idx)*ELEM_W +: ELEM_W] = mac;
            default: begin
              res_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == EXEC);
    bus.done   = (state_q == DONE);
    bus.error  = err_q;
    bus.result = res_q;
  end
endmodule

// File: tb/tb_matrix_alu.sv
// Directed bench for matrix_alu.
// Reference matrices A/B with hand-computed results.
module tb_matrix_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  matrix_alu_if bus ();

  matrix_alu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam int AV[16] = '{4,12,4,34, 7,6,11,9,
                            9,2,8,13, 2,15,16,3};
  localparam int BV[16] = '{23,45,67,22, 7,6,4,1,
                            18,56,13,12, 3,5,7,9};

  logic [255:0] ma, mb, mo;
  int lat, nd, nb, er;

  function automatic logic [15:0] el(logic [255:0] m,
                                     int r, int c);
    return m[(r*4+c)*16 +: 16];
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Start an op, scramble inputs after the start edge,
  // then watch 30 cycles. inj>0 pulses start at that cycle.
  task automatic run_op(input logic [2:0] op,
                        input logic [255:0] a,
                        input logic [255:0] b,
                        input logic [15:0] s,
                        input int inj,
                        output int l, output int n,
                        output int bz, output int e);
    l = 0; n = 0; bz = 0; e = 0;
    @(posedge clk); #1;
    bus.opcode = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.scalar = s;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = '1;
    bus.operand_b = '1;
    bus.scalar = 16'h7;
    bus.opcode = 3'd0;
    if (bus.busy) bz++;
    for (int i = 1; i <= 30; i++) begin
      bus.start = (i == inj);
      @(posedge clk); #1;
      if (bus.busy) bz++;
      if (bus.done) begin
        n++;
        if (l == 0) begin
          l = i;
          e = int'(bus.error);
        end
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.scalar = '0;
    for (int i = 0; i < 16; i++) begin
      ma[i*16 +: 16] = 16'(AV[i]);
      mb[i*16 +: 16] = 16'(BV[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.error), 0);
    chk("rst_res", 32'(bus.result != '0), 0);
    reset = 1'b0;

    run_op(3'd0, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("add_lat", lat, 2);
    chk("add_nd", nd, 1);
    chk("add_busy", nb, 2);
    chk("add_err", er, 0);
    chk("add_00", el(bus.result, 0, 0), 27);
    chk("add_33", el(bus.result, 3, 3), 12);
    chk("add_12", el(bus.result, 1, 2), 15);

    run_op(3'd1, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("sub_lat", lat, 2);
    chk("sub_00", el(bus.result, 0, 0), 65517);
    chk("sub_10", el(bus.result, 1, 0), 0);
    chk("sub_33", el(bus.result, 3, 3), 65530);

    run_op(3'd2, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("mul_lat", lat, 17);
    chk("mul_nd", nd, 1);
    chk("mul_busy", nb, 17);
    chk("mul_00", el(bus.result, 0, 0), 350);
    chk("mul_01", el(bus.result, 0, 1), 646);
    chk("mul_33", el(bus.result, 3, 3), 278);

    run_op(3'd2, ma, mb, 16'd0, 5, lat, nd, nb, er);
    chk("inj_lat", lat, 17);
    chk("inj_nd", nd, 1);
    chk("inj_00", el(bus.result, 0, 0), 350);

    run_op(3'd3, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("tr_lat", lat, 2);
    chk("tr_01", el(bus.result, 0, 1), 7);
    chk("tr_30", el(bus.result, 3, 0), 34);

    run_op(3'd4, ma, mb, 16'd3, 0, lat, nd, nb, er);
    chk("sc_03", el(bus.result, 0, 3), 102);

    mo = ma;
    mo[15:0] = 16'hFFFF;
    run_op(3'd4, mo, mb, 16'd2, 0, lat, nd, nb, er);
    chk("sc_ovf", el(bus.result, 0, 0), 32'hFFFE);
    chk("sc_ovf03", el(bus.result, 0, 3), 68);

    // Abort a mul in its 8th EXEC cycle.
    @(posedge clk); #1;
    bus.opcode = 3'd2;
    bus.operand_a = ma;
    bus.operand_b = mb;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("ab_busy_pre", 32'(bus.busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_res", 32'(bus.result != '0), 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) nd++;
      @(posedge clk); #1;
    end
    chk("ab_nd", nd, 0);

    run_op(3'd0, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("add2_00", el(bus.result, 0, 0), 27);

    run_op(3'd7, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("ill_lat", lat, 2);
    chk("ill_err", er, 1);
    chk("ill_res", 32'(bus.result != '0), 0);
    chk("ill_hold", 32'(bus.error), 1);

    run_op(3'd0, ma, mb, 16'd0, 0, lat, nd, nb, er);
    chk("clr_err", er, 0);
    chk("clr_00", el(bus.result, 0, 0), 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 want=1");
    $fatal(1, "timeout");
  end
endmodule
